// File: rtl/scan_decoder_pkg.sv
// Shared FSM state type and default parameter values for scan_decoder.
package scan_decoder_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DEF_SEL_W   = 3;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_DWELL_W = 8;
endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter; flags expiry while the count sits at 1.
module dwell_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_expire
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expire = (r_cnt == W'(1));
endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with an optional walking-one scan mode.
// Scan mode (SCAN state, dwell counter, scan ports) is compiled in by SCAN_DECODER_SCAN_EN.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               scan_start,
    input  logic               scan_stop,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   res,
    output logic               res_valid,
    output logic               err,
    output logic               busy,
    output logic               scan_done
);
    logic [OUT_W-1:0] r_res;
    logic             r_res_valid;
    logic             r_err;
    logic             w_oor;
    logic [OUT_W-1:0] w_dec;

    // Out-of-range selects saturate to the top bit and raise err.
    assign w_oor = (int'(sel) >= OUT_W);
    assign w_dec = w_oor ? (OUT_W'(1) << (OUT_W - 1)) : (OUT_W'(1) << sel);

`ifdef SCAN_DECODER_SCAN_EN
    state_t             r_state;
    logic               r_busy;
    logic               r_scan_done;
    logic [DWELL_W-1:0] r_reload;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_expire;
    logic               w_last;
    logic               w_load;
    logic               w_clr;

    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign w_last      = r_res[OUT_W-1];
    assign w_load      = (r_state == IDLE && scan_start) ||
                         (r_state == SCAN && !scan_stop && w_expire && !w_last);
    assign w_clr       = (r_state == SCAN) && (scan_stop || (w_expire && w_last));

    dwell_counter #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_load   (w_load),
        .i_en     (r_state == SCAN),
        .i_val    ((r_state == IDLE) ? w_dwell_eff : r_reload),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
            r_reload    <= '0;
        end else begin
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_scan_done <= 1'b0;
            if (r_state == IDLE) begin
                // scan_start outranks a same-cycle decode request
                if (scan_start) begin
                    r_state  <= SCAN;
                    r_res    <= OUT_W'(1);
                    r_reload <= w_dwell_eff;
                    r_busy   <= 1'b1;
                end else if (in_valid) begin
                    r_res       <= w_dec;
                    r_res_valid <= 1'b1;
                    r_err       <= w_oor;
                end
            end else if (scan_stop) begin
                r_state <= IDLE;
                r_res   <= '0;
                r_busy  <= 1'b0;
            end else if (w_expire) begin
                if (w_last) begin
                    r_state     <= IDLE;
                    r_res       <= '0;
                    r_busy      <= 1'b0;
                    r_scan_done <= 1'b1;
                end else begin
                    r_res <= r_res << 1;
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = r_busy;
    assign scan_done = r_scan_done;
`else
    logic w_unused_scan;
    assign w_unused_scan = ^{scan_start, scan_stop, dwell};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            if (in_valid) begin
                r_res       <= w_dec;
                r_res_valid <= 1'b1;
                r_err       <= w_oor;
            end
        end
    end

    assign in_ready  = 1'b1;
    assign busy      = 1'b0;
    assign scan_done = 1'b0;
`endif

    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign err       = r_err;
endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench: two decoders (OUT_W=8 and OUT_W=6) share stimulus and are
// compared each cycle against a plan-based reference model.
module tb_scan_decoder;
`ifdef SCAN_DECODER_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sel = '0;
    logic       in_valid = 1'b0;
    logic       scan_start = 1'b0;
    logic       scan_stop = 1'b0;
    logic [7:0] dwell = '0;

    logic [7:0] res8;
    logic [5:0] res6;
    logic [1:0] rdy, rv, er, bz, dn;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .OUT_W(8), .DWELL_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid), .in_ready(rdy[0]),
        .scan_start(scan_start), .scan_stop(scan_stop), .dwell(dwell),
        .res(res8), .res_valid(rv[0]), .err(er[0]), .busy(bz[0]), .scan_done(dn[0]));

    scan_decoder #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid), .in_ready(rdy[1]),
        .scan_start(scan_start), .scan_stop(scan_stop), .dwell(dwell),
        .res(res6), .res_valid(rv[1]), .err(er[1]), .busy(bz[1]), .scan_done(dn[1]));

    typedef struct packed {
        logic [1:0][7:0] res;
        logic [1:0]      rv, err, busy, done, rdy;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: a scan is a precomputed list of res values, one per cycle.
    logic [7:0] plan [2][2048];
    int         phead [2];
    int         plen [2];
    logic [7:0] mres [2];
    logic [1:0] m_rv, m_err, m_done;

    task automatic model(input int k, input int ow);
        int d;
        m_rv[k] = 1'b0; m_err[k] = 1'b0; m_done[k] = 1'b0;
        if (!rst_n) begin
            plen[k] = 0; mres[k] = '0;
        end else if (plen[k] > 0) begin
            if (scan_stop) begin
                plen[k] = 0; mres[k] = '0;
            end else begin
                phead[k]++; plen[k]--;
                if (plen[k] == 0) begin
                    mres[k] = '0; m_done[k] = 1'b1;
                end else begin
                    mres[k] = plan[k][phead[k]];
                end
            end
        end else if (SCAN_EN && scan_start) begin
            d = (dwell == 0) ? 1 : int'(dwell);
            phead[k] = 0; plen[k] = 0;
            for (int b = 0; b < ow; b++)
                for (int j = 0; j < d; j++) begin
                    plan[k][plen[k]] = 8'(1 << b);
                    plen[k]++;
                end
            mres[k] = 8'd1;
        end else if (in_valid) begin
            m_rv[k] = 1'b1;
            if (int'(sel) >= ow) begin
                mres[k] = 8'(1 << (ow - 1)); m_err[k] = 1'b1;
            end else begin
                mres[k] = 8'(1 << sel);
            end
        end
    endtask

    task automatic step(input bit r, input logic [2:0] s, input bit v,
                        input bit st, input bit sp, input logic [7:0] dw);
        snap_t e;
        @(negedge clk);
        rst_n = r; sel = s; in_valid = v; scan_start = st; scan_stop = sp; dwell = dw;
        model(0, 8);
        model(1, 6);
        for (int k = 0; k < 2; k++) begin
            e.res[k]  = mres[k];
            e.busy[k] = (plen[k] > 0);
            e.rdy[k]  = (plen[k] == 0);
        end
        e.rv = m_rv; e.err = m_err; e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 3'($urandom_range(0, 7)), 0, 0, 0, 8'($urandom_range(0, 9)));
    endtask

    function automatic void chk(input string nm, input int k, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h at %0t", nm, k, got, want, $time);
        end
    endfunction

    // Monitor: the DUT presents a new output state after every rising edge.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("res", 0, res8, e.res[0]);
                chk("res", 1, {2'b00, res6}, e.res[1]);
                for (int k = 0; k < 2; k++) begin
                    chk("res_valid", k, 8'(rv[k]), 8'(e.rv[k]));
                    chk("err", k, 8'(er[k]), 8'(e.err[k]));
                    chk("busy", k, 8'(bz[k]), 8'(e.busy[k]));
                    chk("scan_done", k, 8'(dn[k]), 8'(e.done[k]));
                    chk("in_ready", k, 8'(rdy[k]), 8'(e.rdy[k]));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        plen = '{0, 0}; phead = '{0, 0}; mres = '{8'd0, 8'd0};
        // reset state
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 2);
        // decode sel=5, then hold
        step(1, 3'b101, 1, 0, 0, 0);
        idle(2);
        // sel=7: in range for 8 outputs, out of range for 6
        step(1, 3'd7, 1, 0, 0, 0);
        step(1, 3'd6, 1, 0, 0, 0);
        step(1, 3'd0, 1, 0, 0, 0);
        idle(1);
        // full scan at dwell=2, with ignored restart and decode attempts
        step(1, 0, 0, 1, 0, 8'd2);
        step(1, 3'd3, 1, 1, 0, 8'd7);
        idle(18);
        // collision: scan_start wins over in_valid, dwell=0 acts as 1
        step(1, 3'd2, 1, 1, 0, 8'd0);
        idle(10);
        // abort at position 3
        step(1, 0, 0, 1, 0, 8'd1);
        idle(3);
        step(1, 0, 0, 0, 1, 8'd1);
        idle(10);
        // scan_stop in idle is ignored
        step(1, 3'd4, 1, 0, 1, 8'd0);
        // reset mid-scan
        step(1, 0, 0, 1, 0, 8'd3);
        idle(4);
        step(0, 0, 0, 0, 0, 8'd3);
        step(1, 3'd1, 1, 0, 0, 8'd0);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 29) == 0), 8'($urandom_range(0, 4)));
        idle(2);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
